// File: rtl/tb_uart_sniffer_pkg.sv
// Shared types and default sizing for the UART line sniffer.
// Holds the receiver FSM state encoding and the default bit/buffer parameters.
// The optional PARITY state exists only when TB_UART_SNIFFER_PARITY_EN is defined.
package tb_uart_sniffer_pkg;

    localparam int unsigned DefaultClkDiv    = 16;
    localparam int unsigned DefaultFifoDepth = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TB_UART_SNIFFER_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with optional fall-through output.
// Latency: one cycle push-to-output (zero when FALL_THROUGH and empty).
// Backpressure: push ignored while full, pop ignored while empty.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned Depth = (DEPTH > 0) ? DEPTH : 1;
    localparam int unsigned CntW  = ADDR_DEPTH + 1;
    localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(Depth - 1);
    localparam logic [CntW-1:0]       FullCnt = CntW'(Depth);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  do_push, do_pop;
    dtype                  mem_q [Depth];

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        data_o   = mem_q[rd_ptr_q];
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        // A fall-through byte consumed in the same cycle never touches storage.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                do_push = 1'b0;
                do_pop  = 1'b0;
            end
        end
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push && !flush_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/tb_uart_sniffer.sv
// UART 8N1 receiver (8E1 with TB_UART_SNIFFER_PARITY_EN) feeding a byte FIFO.
// Latency: valid_o rises the cycle after the stop-bit sample (2 extra for rx sync).
// Backpressure: ready_i drains the FIFO; a full FIFO drops the byte and pulses overflow_o.
module tb_uart_sniffer
    import tb_uart_sniffer_pkg::*;
#(
    parameter int unsigned ClkDiv    = DefaultClkDiv,
    parameter int unsigned FifoDepth = DefaultFifoDepth
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_err_o,
    output logic        overflow_o,
    output logic [15:0] rx_count_o
);

    localparam int unsigned     CntW     = $clog2(ClkDiv);
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClkDiv / 2 - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(ClkDiv - 1);

    logic [1:0]      sync_q, sync_d;
    logic            rxs;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     rx_count_q, rx_count_d;
    logic            sample, push_req;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]      fifo_data;
`ifdef TB_UART_SNIFFER_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    assign sync_d = {sync_q[0], rx_i};
    assign rxs    = sync_q[1];
    assign sample = (cnt_q == '0);

    // Counter is preloaded while idle so START lands exactly mid start-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
`ifdef TB_UART_SNIFFER_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = HalfLoad;
`ifdef TB_UART_SNIFFER_PARITY_EN
                par_err_d = 1'b0;
`endif
                if (!rxs) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                if (sample) begin
                    cnt_d   = BitLoad;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d   = BitLoad;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef TB_UART_SNIFFER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef TB_UART_SNIFFER_PARITY_EN
            PARITY: begin
                if (sample) begin
                    cnt_d     = BitLoad;
                    par_err_d = (^shift_q) ^ rxs;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    cnt_d = BitLoad;
                    if (!rxs) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
`ifdef TB_UART_SNIFFER_PARITY_EN
                    end else if (par_err_q) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
`endif
                    end else begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full buffer drops the byte even when a pop frees a slot this cycle.
    assign fifo_push  = push_req && !fifo_full;
    assign fifo_pop   = ready_i && !fifo_empty;
    assign overflow_d = push_req && fifo_full;
    assign rx_count_d = fifo_push ? rx_count_q + 16'd1 : rx_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            rx_count_q  <= '0;
`ifdef TB_UART_SNIFFER_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            rx_count_q  <= rx_count_d;
`ifdef TB_UART_SNIFFER_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (8),
        .DEPTH        (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (shift_q),
        .push_i  (fifo_push),
        .data_o  (fifo_data),
        .pop_i   (fifo_pop)
    );

    assign valid_o     = !fifo_empty;
    assign data_o      = valid_o ? fifo_data : 8'h00;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
    assign rx_count_o  = rx_count_q;

endmodule
